// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
//
// Character-stream terminal front end. Accepts one character at a time over a
// valid/ready handshake and turns it into bus writes toward a memory-mapped
// text RAM (ROWS x COLS cells, one byte per cell at VIDEO_ADDR) plus two
// hardware-cursor registers at VIDEO_ADDR+0xFFE (column+1) and
// VIDEO_ADDR+0xFFD (row).
//
// Control codes: LF (new line), CR (column 0), BS (column back by one),
// FF (clear screen, home cursor). Codes 0x20-0xFF except 0x7F are printed.
// Moving onto a new row clears that row; there is no scrolling, so the row
// index simply wraps from ROWS-1 back to 0.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   char_valid : character offered by the source
//   char_data  : character code
//   char_ready : block can accept a character this cycle (IDLE only)
//   strobe     : bus write strobe, one write per busy cycle
//   rw         : bus direction, 1 = write
//   addr       : bus byte address
//   d_out      : bus write data, bits 31:8 always 0
//   cur_row    : cursor row, 0-based
//   cur_col    : cursor column, 0-based
// -----------------------------------------------------------------------------
`ifndef VIDEO_ADDR
`define VIDEO_ADDR 32'h0000_0000
`endif

module text_console #(
    parameter logic [31:0] VIDEO_ADDR = `VIDEO_ADDR,
    parameter int          ROWS       = 40,
    parameter int          COLS       = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        strobe,
    output logic        rw,
    output logic [31:0] addr,
    output logic [31:0] d_out,
    output logic [5:0]  cur_row,
    output logic [6:0]  cur_col
);

    localparam int          CELLS    = ROWS * COLS;
    localparam int          CW       = $clog2(CELLS + 1);
    localparam logic [31:0] CRX_ADDR = VIDEO_ADDR + 32'h0000_0FFE;
    localparam logic [31:0] CRY_ADDR = VIDEO_ADDR + 32'h0000_0FFD;
    localparam logic [31:0] SPACE    = 32'h0000_0020;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        PUTC,
        CLEAR,
        CURX,
        CURY
    } state_t;

    state_t        state;
    logic [CW-1:0] clr_idx;    // index of the next cell to clear
    logic [CW-1:0] clr_len;    // cells in the current clear run
    logic [31:0]   clr_base;   // address of the first cell of the run
    logic          clr_home;   // clear came from FF: home the cursor at the end
    logic          adv_col;    // printable without wrap: column steps after CURX

    logic [7:0]  col_inc;
    logic        col_wrap;
    logic [5:0]  row_next;
    logic [6:0]  col_bs;
    logic [31:0] cell_addr;
    logic [31:0] next_row_addr;
    logic        printable;

    // col_inc is one bit wider than cur_col so that COLS itself is representable.
    assign col_inc       = {1'b0, cur_col} + 8'd1;
    assign col_wrap      = (32'(col_inc) == 32'(COLS));
    assign row_next      = (32'(cur_row) == 32'(ROWS - 1)) ? 6'd0 : cur_row + 6'd1;
    assign col_bs        = (cur_col != 7'd0) ? cur_col - 7'd1 : cur_col;
    assign cell_addr     = VIDEO_ADDR + 32'(cur_row) * 32'(COLS) + 32'(cur_col);
    assign next_row_addr = VIDEO_ADDR + 32'(row_next) * 32'(COLS);
    assign printable     = (char_data >= 8'h20) && (char_data != 8'h7F);

    assign char_ready = (state == IDLE);

    // Bus outputs are registered: the write that belongs to a state is set up
    // on the edge that enters that state, so strobe/addr/d_out are valid for
    // the whole cycle spent in it. char_data is captured straight into d_out
    // at acceptance, so later changes on the input cannot disturb the write.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking assignment would let later
    // statements see half-updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_row  <= '0;
            cur_col  <= '0;
            strobe   <= 1'b0;
            rw       <= 1'b0;
            addr     <= '0;
            d_out    <= '0;
            clr_idx  <= '0;
            clr_len  <= '0;
            clr_base <= '0;
            clr_home <= 1'b0;
            adv_col  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        strobe <= 1'b1;
                        rw     <= 1'b1;
                        if (printable) begin
                            state <= PUTC;
                            addr  <= cell_addr;
                            d_out <= {24'd0, char_data};
                        end else begin
                            case (char_data)
                                CH_LF: begin
                                    cur_col  <= '0;
                                    cur_row  <= row_next;
                                    state    <= CLEAR;
                                    addr     <= next_row_addr;
                                    d_out    <= SPACE;
                                    clr_base <= next_row_addr;
                                    clr_len  <= CW'(COLS);
                                    clr_idx  <= CW'(1);
                                    clr_home <= 1'b0;
                                end
                                CH_FF: begin
                                    state    <= CLEAR;
                                    addr     <= VIDEO_ADDR;
                                    d_out    <= SPACE;
                                    clr_base <= VIDEO_ADDR;
                                    clr_len  <= CW'(CELLS);
                                    clr_idx  <= CW'(1);
                                    clr_home <= 1'b1;
                                end
                                CH_CR: begin
                                    cur_col <= '0;
                                    state   <= CURX;
                                    addr    <= CRX_ADDR;
                                    d_out   <= 32'd1;
                                end
                                CH_BS: begin
                                    cur_col <= col_bs;
                                    state   <= CURX;
                                    addr    <= CRX_ADDR;
                                    d_out   <= 32'(col_bs) + 32'd1;
                                end
                                default: begin
                                    state <= CURX;
                                    addr  <= CRX_ADDR;
                                    d_out <= 32'(col_inc);
                                end
                            endcase
                        end
                    end
                end

                PUTC: begin
                    if (col_wrap) begin
                        cur_col  <= '0;
                        cur_row  <= row_next;
                        state    <= CLEAR;
                        addr     <= next_row_addr;
                        d_out    <= SPACE;
                        clr_base <= next_row_addr;
                        clr_len  <= CW'(COLS);
                        clr_idx  <= CW'(1);
                        clr_home <= 1'b0;
                    end else begin
                        // The cursor register reports the column the character
                        // was written to, plus one; the column itself steps once
                        // CURX is done.
                        adv_col <= 1'b1;
                        state   <= CURX;
                        addr    <= CRX_ADDR;
                        d_out   <= 32'(col_inc);
                    end
                end

                CLEAR: begin
                    if (clr_idx == clr_len) begin
                        // The column is 0 on every exit from CLEAR (row advance
                        // or home), so the cursor-X value is always 1.
                        if (clr_home) begin
                            cur_row <= '0;
                            cur_col <= '0;
                        end
                        state <= CURX;
                        addr  <= CRX_ADDR;
                        d_out <= 32'd1;
                    end else begin
                        addr    <= clr_base + 32'(clr_idx);
                        clr_idx <= clr_idx + CW'(1);
                    end
                end

                CURX: begin
                    if (adv_col) begin
                        cur_col <= col_inc[6:0];
                    end
                    adv_col <= 1'b0;
                    state   <= CURY;
                    addr    <= CRY_ADDR;
                    d_out   <= 32'(cur_row);
                end

                CURY: begin
                    state  <= IDLE;
                    strobe <= 1'b0;
                    rw     <= 1'b0;
                    addr   <= '0;
                    d_out  <= '0;
                end

                default: begin
                    state  <= IDLE;
                    strobe <= 1'b0;
                    rw     <= 1'b0;
                    addr   <= '0;
                    d_out  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// -----------------------------------------------------------------------------
// tb_text_console
//
// Directed testbench for text_console. A bus monitor logs every write (sampled
// on the falling edge); each stimulus step sends one character, counts the busy
// cycles until char_ready returns, and compares the logged writes and cursor
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_text_console;

    localparam logic [31:0] VA  = 32'h0001_0000;
    localparam logic [31:0] CRX = VA + 32'h0000_0FFE;
    localparam logic [31:0] CRY = VA + 32'h0000_0FFD;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data  = 8'h00;
    logic        char_ready;
    logic        strobe;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] d_out;
    logic [5:0]  cur_row;
    logic [6:0]  cur_col;

    text_console #(
        .VIDEO_ADDR (VA),
        .ROWS       (40),
        .COLS       (80)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .strobe     (strobe),
        .rw         (rw),
        .addr       (addr),
        .d_out      (d_out),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          bus_bad = 0;

    always @(negedge clk) begin
        if (strobe) begin
            log_addr.push_back(addr);
            log_data.push_back(d_out);
        end
        if (strobe != rw) bus_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] a, input logic [31:0] d);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, log_addr[idx], a);
            check({tag, "_data"}, log_data[idx], d);
        end else begin
            check({tag, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    // n consecutive writes of 0x20 starting at log entry 'first', address base+i.
    task automatic check_clear(input string tag, input int first,
                               input logic [31:0] base, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i >= log_addr.size()) bad++;
            else if (log_addr[first + i] != base + 32'(i) || log_data[first + i] != 32'h20) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    // Called on a falling edge with char_ready high. Returns the number of
    // falling edges seen with char_ready low (one per busy cycle). With junk
    // set, a different character is offered during the first busy cycle.
    task automatic send(input logic [7:0] c, input bit junk, output int busy);
        log_addr.delete();
        log_data.delete();
        char_data  = c;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            char_data = 8'h0C;
        end else begin
            char_valid = 1'b0;
            char_data  = 8'h00;
        end
        busy = 0;
        while (!char_ready && busy < 5000) begin
            busy++;
            @(negedge clk);
            char_valid = 1'b0;
        end
    endtask

    initial begin
        int busy;
        int bad;
        int n;

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobe", strobe, 1'b0);
        check("rst_rw", rw, 1'b0);
        check("rst_addr", addr, 32'd0);
        check("rst_dout", d_out, 32'd0);
        check("rst_row", cur_row, 6'd0);
        check("rst_col", cur_col, 7'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_ready", char_ready, 1'b1);
        repeat (2) @(negedge clk);
        check("rel_no_write", 32'(log_addr.size()), 32'd0);

        // 'A' at 0/0; a stray FF offered while busy must be ignored
        send(8'h41, 1'b1, busy);
        check("A_busy", 32'(busy), 32'd3);
        check("A_nwr", 32'(log_addr.size()), 32'd3);
        check_write("A_text", 0, VA, 32'h41);
        check_write("A_crx", 1, CRX, 32'd1);
        check_write("A_cry", 2, CRY, 32'd0);
        check("A_col", cur_col, 7'd1);
        check("A_row", cur_row, 6'd0);

        // CR back to column 0
        send(8'h0D, 1'b0, busy);
        check("CR_busy", 32'(busy), 32'd2);
        check_write("CR_crx", 0, CRX, 32'd1);
        check_write("CR_cry", 1, CRY, 32'd0);
        check("CR_col", cur_col, 7'd0);

        // 79 'x' fill columns 0..78
        bad = 0;
        for (int i = 0; i < 79; i++) begin
            send(8'h78, 1'b0, busy);
            if (busy != 3 || log_addr.size() != 3) bad++;
            else if (log_addr[0] != VA + 32'(i) || log_data[0] != 32'h78 ||
                     log_data[1] != 32'(i + 1)) bad++;
        end
        check("x_fill", 32'(bad), 32'd0);

        // 80th 'x' wraps: write col 79, clear row 1, cursor 0/1
        send(8'h78, 1'b0, busy);
        check("x80_busy", 32'(busy), 32'd83);
        check("x80_nwr", 32'(log_addr.size()), 32'd83);
        check_write("x80_text", 0, VA + 32'd79, 32'h78);
        check_clear("x80_clear", 1, VA + 32'd80, 80);
        check_write("x80_crx", 81, CRX, 32'd1);
        check_write("x80_cry", 82, CRY, 32'd1);
        check("x80_row", cur_row, 6'd1);
        check("x80_col", cur_col, 7'd0);

        // BS at column 0
        send(8'h08, 1'b0, busy);
        check("BS0_busy", 32'(busy), 32'd2);
        check_write("BS0_crx", 0, CRX, 32'd1);
        check_write("BS0_cry", 1, CRY, 32'd1);
        check("BS0_col", cur_col, 7'd0);

        // BS at column 5
        for (int i = 0; i < 5; i++) send(8'h61, 1'b0, busy);
        check("BS5_pre_col", cur_col, 7'd5);
        send(8'h08, 1'b0, busy);
        check("BS5_busy", 32'(busy), 32'd2);
        check("BS5_nwr", 32'(log_addr.size()), 32'd2);
        check_write("BS5_crx", 0, CRX, 32'd5);
        check_write("BS5_cry", 1, CRY, 32'd1);
        check("BS5_col", cur_col, 7'd4);
        check("BS5_row", cur_row, 6'd1);

        // LF x38 takes the cursor from row 1 to row 39
        bad = 0;
        for (int i = 0; i < 38; i++) begin
            send(8'h0A, 1'b0, busy);
            if (busy != 82) bad++;
        end
        check("LF_walk_busy", 32'(bad), 32'd0);
        check("LF_walk_row", cur_row, 6'd39);
        check("LF_walk_col", cur_col, 7'd0);

        // LF on the last row wraps to row 0 and clears it
        send(8'h0A, 1'b0, busy);
        check("LF39_busy", 32'(busy), 32'd82);
        check_clear("LF39_clear", 0, VA, 80);
        check_write("LF39_crx", 80, CRX, 32'd1);
        check_write("LF39_cry", 81, CRY, 32'd0);
        check("LF39_row", cur_row, 6'd0);

        // 0x7F is not printable
        send(8'h7F, 1'b0, busy);
        check("DEL_busy", 32'(busy), 32'd2);
        check_write("DEL_crx", 0, CRX, 32'd1);
        check("DEL_col", cur_col, 7'd0);

        // 0xFF is printable
        send(8'hFF, 1'b0, busy);
        check("FFh_busy", 32'(busy), 32'd3);
        check_write("FFh_text", 0, VA, 32'hFF);
        check("FFh_col", cur_col, 7'd1);

        // 0x1F is just below the printable range
        send(8'h1F, 1'b0, busy);
        check("1F_busy", 32'(busy), 32'd2);
        check_write("1F_crx", 0, CRX, 32'd2);
        check("1F_col", cur_col, 7'd1);

        // 0x20 is the first printable code
        send(8'h20, 1'b0, busy);
        check("20_busy", 32'(busy), 32'd3);
        check_write("20_text", 0, VA + 32'd1, 32'h20);
        check_write("20_crx", 1, CRX, 32'd2);
        check("20_col", cur_col, 7'd2);

        // FF clears the whole screen and homes the cursor
        send(8'h0C, 1'b0, busy);
        check("FF_busy", 32'(busy), 32'd3202);
        check("FF_nwr", 32'(log_addr.size()), 32'd3202);
        check_clear("FF_clear", 0, VA, 3200);
        check_write("FF_crx", 3200, CRX, 32'd1);
        check_write("FF_cry", 3201, CRY, 32'd0);
        check("FF_row", cur_row, 6'd0);
        check("FF_col", cur_col, 7'd0);

        // Reset during the 10th CLEAR cycle of an LF
        log_addr.delete();
        log_data.delete();
        char_data  = 8'h0A;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_strobe_before", strobe, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_strobe", strobe, 1'b0);
        check("mid_rw", rw, 1'b0);
        check("mid_addr", addr, 32'd0);
        n = log_addr.size();
        check("mid_nwr_before", 32'(n), 32'd10);
        repeat (3) @(negedge clk);
        check("mid_nwr_held", 32'(log_addr.size()), 32'd10);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_ready", char_ready, 1'b1);
        check("mid_row", cur_row, 6'd0);
        check("mid_col", cur_col, 7'd0);
        check("mid_nwr_after", 32'(log_addr.size()), 32'd10);

        check("bus_strobe_rw", 32'(bus_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
